// File: rtl/ram_arb_pkg.sv
// Shared types for the data-RAM arbiter: FSM states, read owners and the
// return-pipe tag that travels alongside each granted access.
package ram_arb_pkg;

    typedef enum logic {C_PRI = 1'b0, H_FORCE = 1'b1} arb_state_t;

    typedef enum logic {OWN_C = 1'b0, OWN_H = 1'b1} owner_t;

    typedef struct packed {
        logic   v;
        owner_t own;
    } rd_tag_t;

    localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/rd_return_pipe.sv
// Delay line of read tags matching the RAM read latency, so each returning
// datum can be steered to the port that issued it.
module rd_return_pipe
    import ram_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t push_tag,
    output rd_tag_t ret_tag
);

    rd_tag_t stage_r [RD_LAT];

    // Shift tags one stage per cycle; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= push_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign ret_tag = stage_r[RD_LAT-1];

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the single-port data RAM between the pipeline MEM stage (C, high
// priority) and the host port (H), with a starvation guard for H.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    output logic          cpu_stall,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q
);

    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT = {WAIT_W{1'b1}};

    arb_state_t        state_r, state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_nxt_s;
    logic              c_gnt_s, h_gnt_s;
    logic [AW-1:0]     addr_hold_r, ram_address_s;
    logic [DW-1:0]     data_hold_r, ram_data_s;
    logic              ram_wren_s;
    rd_tag_t           push_tag_s, ret_tag_s;
    logic              c_rvalid_s, h_rvalid_s;
    logic [DW-1:0]     c_rdata_r, h_rdata_r;

    // Grant selection and next state; H_FORCE hands one slot to a starved host.
    always_comb begin
        c_gnt_s     = 1'b0;
        h_gnt_s     = 1'b0;
        state_nxt_s = C_PRI;
        case (state_r)
            H_FORCE: begin
                if (h_req) begin
                    h_gnt_s = 1'b1;
                end else begin
                    c_gnt_s = c_req;
                end
            end
            default: begin
                if (c_req) begin
                    c_gnt_s = 1'b1;
                end else begin
                    h_gnt_s = h_req;
                end
                if (h_req && !h_gnt_s && (wait_cnt_r == WAIT_LIM)) begin
                    state_nxt_s = H_FORCE;
                end else begin
                    state_nxt_s = C_PRI;
                end
            end
        endcase
    end

    // Starvation counter: counts consecutive denied host cycles, saturating.
    always_comb begin
        wait_cnt_nxt_s = '0;
        if (h_req && !h_gnt_s) begin
            wait_cnt_nxt_s = (wait_cnt_r == WAIT_SAT) ? wait_cnt_r : wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_nxt_s = '0;
        end
    end

    // RAM port mux; with no grant the bus keeps its last driven values.
    always_comb begin
        ram_wren_s    = 1'b0;
        ram_address_s = addr_hold_r;
        ram_data_s    = data_hold_r;
        if (c_gnt_s) begin
            ram_wren_s    = c_we;
            ram_address_s = c_addr;
            ram_data_s    = c_wdata;
        end else if (h_gnt_s) begin
            ram_wren_s    = h_we;
            ram_address_s = h_addr;
            ram_data_s    = h_wdata;
        end else begin
            ram_wren_s    = 1'b0;
        end
    end

    // Tag pushed into the return pipe; writes travel as invalid slots.
    always_comb begin
        push_tag_s.v   = (c_gnt_s & ~c_we) | (h_gnt_s & ~h_we);
        push_tag_s.own = h_gnt_s ? OWN_H : OWN_C;
    end

    rd_return_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst),
        .push_tag (push_tag_s),
        .ret_tag  (ret_tag_s)
    );

    assign c_rvalid_s = ret_tag_s.v && (ret_tag_s.own == OWN_C);
    assign h_rvalid_s = ret_tag_s.v && (ret_tag_s.own == OWN_H);

    // Arbitration state and starvation counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= C_PRI;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Remember the last driven address/data so the bus holds when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_hold_r <= '0;
            data_hold_r <= '0;
        end else if (c_gnt_s || h_gnt_s) begin
            addr_hold_r <= ram_address_s;
            data_hold_r <= ram_data_s;
        end
    end

    // Per-port read data capture so the non-owner keeps its last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_rdata_r <= '0;
            h_rdata_r <= '0;
        end else begin
            if (c_rvalid_s) c_rdata_r <= ram_q;
            if (h_rvalid_s) h_rdata_r <= ram_q;
        end
    end

    assign c_gnt       = c_gnt_s;
    assign h_gnt       = h_gnt_s;
    assign cpu_stall   = c_req & ~c_gnt_s;
    assign ram_wren    = ram_wren_s;
    assign ram_address = ram_address_s;
    assign ram_data    = ram_data_s;
    assign c_rvalid    = c_rvalid_s;
    assign h_rvalid    = h_rvalid_s;
    assign c_rdata     = c_rvalid_s ? ram_q : c_rdata_r;
    assign h_rdata     = h_rvalid_s ? ram_q : h_rdata_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: one instance with RD_LAT=1, one with RD_LAT=3,
// each attached to a behavioural RAM model.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance u1 (RD_LAT=1)
    logic c_req1 = 1'b0, c_we1 = 1'b0, h_req1 = 1'b0, h_we1 = 1'b0;
    logic [31:0] c_addr1 = 32'd0, c_wdata1 = 32'd0, h_addr1 = 32'd0, h_wdata1 = 32'd0;
    logic c_gnt1, c_rvalid1, cpu_stall1, h_gnt1, h_rvalid1, ram_wren1;
    logic [31:0] c_rdata1, h_rdata1, ram_address1, ram_data1, ram_q1;

    // Instance u3 (RD_LAT=3)
    logic c_req3 = 1'b0, c_we3 = 1'b0, h_req3 = 1'b0, h_we3 = 1'b0;
    logic [31:0] c_addr3 = 32'd0, c_wdata3 = 32'd0, h_addr3 = 32'd0, h_wdata3 = 32'd0;
    logic c_gnt3, c_rvalid3, cpu_stall3, h_gnt3, h_rvalid3, ram_wren3;
    logic [31:0] c_rdata3, h_rdata3, ram_address3, ram_data3, ram_q3;

    ram_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .MAX_WAIT(8)) u1 (
        .clk(clk), .rst(rst),
        .c_req(c_req1), .c_we(c_we1), .c_addr(c_addr1), .c_wdata(c_wdata1),
        .c_gnt(c_gnt1), .c_rvalid(c_rvalid1), .c_rdata(c_rdata1), .cpu_stall(cpu_stall1),
        .h_req(h_req1), .h_we(h_we1), .h_addr(h_addr1), .h_wdata(h_wdata1),
        .h_gnt(h_gnt1), .h_rvalid(h_rvalid1), .h_rdata(h_rdata1),
        .ram_address(ram_address1), .ram_data(ram_data1), .ram_wren(ram_wren1), .ram_q(ram_q1)
    );

    ram_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_WAIT(8)) u3 (
        .clk(clk), .rst(rst),
        .c_req(c_req3), .c_we(c_we3), .c_addr(c_addr3), .c_wdata(c_wdata3),
        .c_gnt(c_gnt3), .c_rvalid(c_rvalid3), .c_rdata(c_rdata3), .cpu_stall(cpu_stall3),
        .h_req(h_req3), .h_we(h_we3), .h_addr(h_addr3), .h_wdata(h_wdata3),
        .h_gnt(h_gnt3), .h_rvalid(h_rvalid3), .h_rdata(h_rdata3),
        .ram_address(ram_address3), .ram_data(ram_data3), .ram_wren(ram_wren3), .ram_q(ram_q3)
    );

    // Preloaded RAM contents: 0x10 holds 0xCAFE0001, every other word 0x50000000+addr.
    function automatic logic [31:0] init_word(input logic [7:0] a);
        init_word = (a == 8'h10) ? 32'hCAFE_0001 : (32'h5000_0000 + {24'd0, a});
    endfunction

    logic [31:0]  mem1 [256];
    logic [31:0]  mem3 [256];
    logic [255:0] wr1 = '0;
    logic [255:0] wr3 = '0;
    logic [31:0]  q3a, q3b;

    // RAM models: registered address, write-then-read returns new data.
    always @(posedge clk) begin
        if (ram_wren1) begin
            mem1[ram_address1[7:0]] <= ram_data1;
            wr1[ram_address1[7:0]]  <= 1'b1;
        end
        ram_q1 <= wr1[ram_address1[7:0]] ? mem1[ram_address1[7:0]] : init_word(ram_address1[7:0]);
    end

    always @(posedge clk) begin
        if (ram_wren3) begin
            mem3[ram_address3[7:0]] <= ram_data3;
            wr3[ram_address3[7:0]]  <= 1'b1;
        end
        q3a    <= wr3[ram_address3[7:0]] ? mem3[ram_address3[7:0]] : init_word(ram_address3[7:0]);
        q3b    <= q3a;
        ram_q3 <= q3b;
    end

    typedef struct {
        owner_t      own;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q1 [$];
    exp_t exp_q3 [$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor u1: every rvalid pops one expected return.
    always @(negedge clk) begin
        if (c_rvalid1 || h_rvalid1) begin
            if (exp_q1.size() == 0) begin
                chk("u1_unexpected_rvalid", {62'd0, c_rvalid1, h_rvalid1}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q1.pop_front();
                chk("u1_ret_owner", {62'd0, c_rvalid1, h_rvalid1},
                    (e.own == OWN_C) ? 64'd2 : 64'd1);
                chk("u1_ret_data", {32'd0, (e.own == OWN_C) ? c_rdata1 : h_rdata1}, {32'd0, e.data});
            end
        end
    end

    // Monitor u3.
    always @(negedge clk) begin
        if (c_rvalid3 || h_rvalid3) begin
            if (exp_q3.size() == 0) begin
                chk("u3_unexpected_rvalid", {62'd0, c_rvalid3, h_rvalid3}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q3.pop_front();
                chk("u3_ret_owner", {62'd0, c_rvalid3, h_rvalid3},
                    (e.own == OWN_C) ? 64'd2 : 64'd1);
                chk("u3_ret_data", {32'd0, (e.own == OWN_C) ? c_rdata3 : h_rdata3}, {32'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset for 2 cycles, then idle
        repeat (2) begin
            @(negedge clk);
            chk("t1_rst_flags", {58'd0, c_gnt1, h_gnt1, c_rvalid1, h_rvalid1, cpu_stall1, ram_wren1}, 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t1_idle_flags", {56'd0, c_gnt1, h_gnt1, c_rvalid1, h_rvalid1, cpu_stall1, ram_wren1,
                                  c_rvalid3, h_rvalid3}, 64'd0);
            chk("t1_idle_bus", {ram_address1, c_rdata1 | h_rdata1 | ram_data1}, 64'd0);
        end

        // 2: CPU load @0x10, RD_LAT=1
        @(posedge clk); #1;
        c_req1 = 1'b1; c_we1 = 1'b0; c_addr1 = 32'h10;
        exp_q1.push_back('{OWN_C, 32'hCAFE_0001});
        @(negedge clk);
        chk("t2_c_gnt", {63'd0, c_gnt1}, 64'd1);
        chk("t2_stall", {63'd0, cpu_stall1}, 64'd0);
        chk("t2_ram_addr", {32'd0, ram_address1}, 64'h10);
        chk("t2_ram_wren", {63'd0, ram_wren1}, 64'd0);
        @(posedge clk); #1;
        c_req1 = 1'b0;
        @(negedge clk);
        chk("t2_c_rvalid", {63'd0, c_rvalid1}, 64'd1);
        chk("t2_c_rdata", {32'd0, c_rdata1}, 64'hCAFE_0001);
        chk("t2_addr_hold", {32'd0, ram_address1}, 64'h10);

        // 4: host write @0x40, CPU load @0x40 next cycle
        @(posedge clk); #1;
        h_req1 = 1'b1; h_we1 = 1'b1; h_addr1 = 32'h40; h_wdata1 = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t4_h_gnt", {63'd0, h_gnt1}, 64'd1);
        chk("t4_wr_bus", {31'd0, ram_wren1, ram_data1}, {31'd0, 1'b1, 32'hDEAD_BEEF});
        @(posedge clk); #1;
        h_req1 = 1'b0; h_we1 = 1'b0;
        c_req1 = 1'b1; c_we1 = 1'b0; c_addr1 = 32'h40;
        exp_q1.push_back('{OWN_C, 32'hDEAD_BEEF});
        @(negedge clk);
        chk("t4_c_gnt", {63'd0, c_gnt1}, 64'd1);
        chk("t4_h_rvalid_a", {63'd0, h_rvalid1}, 64'd0);
        @(posedge clk); #1;
        c_req1 = 1'b0;
        @(negedge clk);
        chk("t4_c_rdata", {32'd0, c_rdata1}, 64'hDEAD_BEEF);
        chk("t4_h_rvalid_b", {63'd0, h_rvalid1}, 64'd0);
        chk("t4_h_rdata_hold", {32'd0, h_rdata1}, 64'd0);
        @(negedge clk);
        chk("t4_c_rdata_hold", {31'd0, c_rvalid1, c_rdata1}, {31'd0, 1'b0, 32'hDEAD_BEEF});

        // 3: both requesting for 20 cycles, H forced in cycles 9 and 18
        @(posedge clk); #1;
        c_req1 = 1'b1; c_we1 = 1'b1; c_addr1 = 32'h80; c_wdata1 = 32'h1;
        h_req1 = 1'b1; h_we1 = 1'b1; h_addr1 = 32'h84; h_wdata1 = 32'h2;
        for (int k = 1; k <= 20; k++) begin
            logic f;
            @(negedge clk);
            f = (k == 9) || (k == 18);
            chk("t3_h_gnt", {63'd0, h_gnt1}, {63'd0, f});
            chk("t3_c_gnt", {63'd0, c_gnt1}, {63'd0, ~f});
            chk("t3_stall", {63'd0, cpu_stall1}, {63'd0, f});
        end
        @(posedge clk); #1;
        c_req1 = 1'b0; c_we1 = 1'b0; h_req1 = 1'b0; h_we1 = 1'b0;

        // 5: alternating C/H reads every cycle on RD_LAT=3
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            if (k < 6) begin
                c_req3 = ((k % 2) == 0);
                h_req3 = ((k % 2) == 1);
                c_addr3 = 32'h20 + 32'(k);
                h_addr3 = 32'h20 + 32'(k);
                exp_q3.push_back('{((k % 2) == 0) ? OWN_C : OWN_H, 32'h5000_0020 + 32'(k)});
            end else begin
                c_req3 = 1'b0;
                h_req3 = 1'b0;
            end
            @(negedge clk);
            if (k < 6) begin
                chk("t5_gnt", {62'd0, c_gnt3, h_gnt3}, ((k % 2) == 0) ? 64'd2 : 64'd1);
            end
            if (k >= 3) begin
                chk("t5_rvalid", {62'd0, c_rvalid3, h_rvalid3}, (((k - 3) % 2) == 0) ? 64'd2 : 64'd1);
            end
        end

        // 6: reset one cycle after a granted read
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            c_req1 = 1'b1; c_we1 = (k < 4); c_addr1 = (k < 4) ? 32'h80 : 32'h10;
            h_req1 = 1'b1; h_we1 = 1'b1; h_addr1 = 32'h84;
            if (k == 4) begin
                c_req3 = 1'b1; c_we3 = 1'b0; c_addr3 = 32'h21;
            end
            @(negedge clk);
            chk("t6_c_gnt", {62'd0, c_gnt1, h_gnt1}, 64'd2);
            if (k == 4) begin
                chk("t6_wait_pre", {56'd0, u1.wait_cnt_r}, 64'd3);
                chk("t6_c_gnt3", {63'd0, c_gnt3}, 64'd1);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        c_req1 = 1'b0; c_we1 = 1'b0; h_req1 = 1'b0; h_we1 = 1'b0; c_req3 = 1'b0;
        @(negedge clk);
        chk("t6_wait_rst", {56'd0, u1.wait_cnt_r}, 64'd0);
        chk("t6_state_rst", {63'd0, (u1.state_r == C_PRI)}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_no_rvalid", {60'd0, c_rvalid1, h_rvalid1, c_rvalid3, h_rvalid3}, 64'd0);
        end

        chk("end_q1_empty", 64'(exp_q1.size()), 64'd0);
        chk("end_q3_empty", 64'(exp_q3.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
